cache_nway_wb: RTL and testbench

Parametrised N-way set-associative write-back, write-allocate data cache with true-LRU replacement. It sits between the CPU request port and a line-wide memory port. It adds three things:
- a cycle-level request/ack handshake on the CPU side;
- dirty-line writeback on eviction;
- a full flush (dump) command and hit/miss statistics counters.

---
 rtl/cache_nway_pkg.sv | 78 +++++++
 rtl/cache_lru_set.sv | 57 +++++
 rtl/cache_nway_wb.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_cache_nway_wb.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_nway_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cache_nway_pkg                                                 |
// | Purpose : Shared types, default-geometry widths, size encodings and      |
// |           address/byte-lane helper functions for cache_nway_wb.          |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package cache_nway_pkg;

  // Widths of the default geometry (2 ways, 32 sets, 16-byte lines, 19-bit
  // addresses). Instances with other parameters derive their own widths.
  localparam int DEF_WAYS       = 2;
  localparam int DEF_SETS       = 32;
  localparam int DEF_LINE_BYTES = 16;
  localparam int DEF_ADDR_W     = 19;
  localparam int DEF_OFFSET_W   = $clog2(DEF_LINE_BYTES);
  localparam int DEF_SET_W      = $clog2(DEF_SETS);
  localparam int DEF_TAG_W      = DEF_ADDR_W - DEF_SET_W - DEF_OFFSET_W;
  localparam int DEF_AGE_W      = $clog2(DEF_WAYS);
  localparam int DEF_LINE_W     = DEF_LINE_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    WB       = 3'd2,
    FILL     = 3'd3,
    ACK      = 3'd4,
    FL_SCAN  = 3'd5,
    FL_WB    = 3'd6,
    FL_DONE  = 3'd7
  } state_t;

  localparam logic [1:0] SZ_8  = 2'd0;
  localparam logic [1:0] SZ_16 = 2'd1;
  localparam logic [1:0] SZ_32 = 2'd2;

  // Number of bytes moved by an access; encoding 3 behaves as 32-bit.
  function automatic int unsigned size_bytes(input logic [1:0] size);
    case (size)
      SZ_8:    size_bytes = 1;
      SZ_16:   size_bytes = 2;
      default: size_bytes = 4;
    endcase
  endfunction

  // Force the line offset to the natural alignment of the access size.
  function automatic logic [7:0] align_off(input logic [7:0] off, input logic [1:0] size);
    case (size)
      SZ_8:    align_off = off;
      SZ_16:   align_off = {off[7:1], 1'b0};
      default: align_off = {off[7:2], 2'b00};
    endcase
  endfunction

  // Extract a [lo +: width] field of a byte address (tag/set/offset split).
  function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                             input int unsigned lo,
                                             input int unsigned width);
    addr_field = (addr >> lo) & ((32'd1 << width) - 32'd1);
  endfunction

  // For line byte k: bit 2 says whether the access covers it, bits [1:0]
  // give the byte position inside the right-justified 32-bit access word.
  // Big-endian: the lowest line offset maps to the most significant byte.
  function automatic logic [2:0] lane_sel(input logic [7:0] off_al,
                                          input logic [1:0] size,
                                          input int unsigned k);
    int unsigned o;
    int unsigned nb;
    o  = 32'(off_al);
    nb = size_bytes(size);
    lane_sel = 3'b000;
    if (k >= o && k < o + nb) lane_sel = {1'b1, 2'(nb - 1 - (k - o))};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_lru_set.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cache_lru_set                                                  |
// | Purpose : True-LRU age logic for one set. Computes the updated age       |
// |           vector for an access and the replacement victim.               |
// | Ports   : ages     - current ages, one AGE_W field per way                |
// |           valid    - per-way valid bits of the set                        |
// |           access   - an access to 'way' is being recorded                 |
// |           way      - accessed way                                         |
// |           ages_nxt - ages after the access (== ages when !access)        |
// |           victim   - lowest invalid way, else the oldest way              |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module cache_lru_set #(
  parameter int WAYS  = 2,
  parameter int AGE_W = 1
) (
  input  logic [WAYS-1:0][AGE_W-1:0] ages,
  input  logic [WAYS-1:0]            valid,
  input  logic                       access,
  input  logic [AGE_W-1:0]           way,
  output logic [WAYS-1:0][AGE_W-1:0] ages_nxt,
  output logic [AGE_W-1:0]           victim
);

  logic found;

  // Ways younger than the accessed one age by one; the accessed way becomes
  // youngest. This keeps the ages a permutation of 0..WAYS-1.
  always_comb begin
    ages_nxt = ages;
    if (access) begin
      for (int w = 0; w < WAYS; w++) begin
        if (ages[w] < ages[way]) ages_nxt[w] = ages[w] + AGE_W'(1);
      end
      ages_nxt[way] = '0;
    end
  end

  always_comb begin
    found  = 1'b0;
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid[w]) begin
        victim = AGE_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (ages[w] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_nway_wb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cache_nway_wb                                                  |
// | Purpose : N-way set-associative write-back / write-allocate data cache   |
// |           with true-LRU replacement, full flush and hit/miss counters.   |
// | Ports   : clk, R (sync active-high reset)                                |
// |           cpu_req/we/size/addr/wdata -> cpu_rdata, cpu_ack (1-cyc pulse) |
// |           flush_req -> flush_done (1-cycle pulse)                        |
// |           mem_req/we/addr/wdata, mem_rdata, mem_ack (line-wide port)     |
// |           hit_cnt, miss_cnt (16-bit saturating)                          |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module cache_nway_wb
  import cache_nway_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 32,
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 19
) (
  input  logic                                   clk,
  input  logic                                   R,
  input  logic                                   cpu_req,
  input  logic                                   cpu_we,
  input  logic [1:0]                             cpu_size,
  input  logic [ADDR_W-1:0]                      cpu_addr,
  input  logic [31:0]                            cpu_wdata,
  output logic [31:0]                            cpu_rdata,
  output logic                                   cpu_ack,
  input  logic                                   flush_req,
  output logic                                   flush_done,
  output logic                                   mem_req,
  output logic                                   mem_we,
  output logic [ADDR_W-$clog2(LINE_BYTES)-1:0]   mem_addr,
  output logic [LINE_BYTES*8-1:0]                mem_wdata,
  input  logic [LINE_BYTES*8-1:0]                mem_rdata,
  input  logic                                   mem_ack,
  output logic [15:0]                            hit_cnt,
  output logic [15:0]                            miss_cnt
);

  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam int SET_W    = $clog2(SETS);
  localparam int TAG_W    = ADDR_W - SET_W - OFFSET_W;
  localparam int AGE_W    = $clog2(WAYS);
  localparam int LINE_W   = LINE_BYTES * 8;

  state_t state;

  // Latched request
  logic [TAG_W-1:0]    req_tag;
  logic [SET_W-1:0]    req_set;
  logic [OFFSET_W-1:0] req_off;   // already aligned
  logic                req_we;
  logic [1:0]          req_size;
  logic [31:0]         req_wdata;
  logic                refill;    // current LOOKUP follows a fill: not a hit
  logic [AGE_W-1:0]    victim_q;

  // Storage
  logic [TAG_W-1:0]              tag_mem  [WAYS][SETS];
  logic [LINE_W-1:0]             data_mem [WAYS][SETS];
  logic [WAYS-1:0]               valid    [SETS];
  logic [WAYS-1:0]               dirty    [SETS];
  logic [WAYS-1:0][AGE_W-1:0]    age      [SETS];

  // Flush walk position: index = fl_way*SETS + fl_set
  logic [AGE_W-1:0] fl_way;
  logic [SET_W-1:0] fl_set;
  logic             fl_last;

  logic                          hit;
  logic [AGE_W-1:0]              hit_way;
  logic [LINE_W-1:0]             hit_line;
  logic [LINE_W-1:0]             merged_line;
  logic [31:0]                   rd_data;
  logic [2:0]                    lane;
  logic [WAYS-1:0][AGE_W-1:0]    ages_nxt;
  logic [AGE_W-1:0]              victim;

  assign fl_last  = (fl_way == AGE_W'(WAYS - 1)) && (fl_set == SET_W'(SETS - 1));
  assign hit_line = data_mem[hit_way][req_set];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[req_set][w] && tag_mem[w][req_set] == req_tag) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  // Read extraction and write merge share the same byte-lane mapping.
  always_comb begin
    rd_data     = '0;
    merged_line = hit_line;
    lane        = '0;
    for (int k = 0; k < LINE_BYTES; k++) begin
      lane = lane_sel(8'(req_off), req_size, k);
      if (lane[2]) begin
        rd_data[8*lane[1:0] +: 8] = hit_line[8*k +: 8];
        merged_line[8*k +: 8]     = req_wdata[8*lane[1:0] +: 8];
      end
    end
  end

  // One LRU engine shared across sets over the registered age array.
  cache_lru_set #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_lru (
    .ages     (age[req_set]),
    .valid    (valid[req_set]),
    .access   (state == LOOKUP && hit),
    .way      (hit_way),
    .ages_nxt (ages_nxt),
    .victim   (victim)
  );

  always_ff @(posedge clk) begin
    if (R) begin
      state      <= IDLE;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
      flush_done <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      req_tag    <= '0;
      req_set    <= '0;
      req_off    <= '0;
      req_we     <= 1'b0;
      req_size   <= '0;
      req_wdata  <= '0;
      refill     <= 1'b0;
      victim_q   <= '0;
      fl_way     <= '0;
      fl_set     <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) age[s][w] <= AGE_W'(w);
      end
    end else begin
      cpu_ack    <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_req) begin
            fl_way <= '0;
            fl_set <= '0;
            state  <= FL_SCAN;
          end else if (cpu_req && !cpu_ack) begin
            // cpu_ack high means the CPU has not yet dropped the request
            // it just completed, so it must not be taken again.
            req_tag   <= TAG_W'(addr_field(32'(cpu_addr), SET_W + OFFSET_W, TAG_W));
            req_set   <= SET_W'(addr_field(32'(cpu_addr), OFFSET_W, SET_W));
            req_off   <= OFFSET_W'(align_off(8'(addr_field(32'(cpu_addr), 0, OFFSET_W)),
                                             cpu_size));
            req_we    <= cpu_we;
            req_size  <= cpu_size;
            req_wdata <= cpu_wdata;
            refill    <= 1'b0;
            state     <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (hit) begin
            if (req_we) begin
              data_mem[hit_way][req_set] <= merged_line;
              dirty[req_set][hit_way]    <= 1'b1;
            end else begin
              cpu_rdata <= rd_data;
            end
            age[req_set] <= ages_nxt;
            if (!refill && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            state <= ACK;
          end else begin
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            victim_q <= victim;
            state    <= (valid[req_set][victim] && dirty[req_set][victim]) ? WB : FILL;
          end
        end

        // Memory phases issue in their first cycle and hold until mem_ack,
        // so a WB followed by FILL always leaves a low cycle on mem_req.
        WB: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {tag_mem[victim_q][req_set], req_set};
            mem_wdata <= data_mem[victim_q][req_set];
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= FILL;
          end
        end

        FILL: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {req_tag, req_set};
          end else if (mem_ack) begin
            mem_req                     <= 1'b0;
            data_mem[victim_q][req_set] <= mem_rdata;
            tag_mem[victim_q][req_set]  <= req_tag;
            valid[req_set][victim_q]    <= 1'b1;
            dirty[req_set][victim_q]    <= 1'b0;
            refill                      <= 1'b1;
            state                       <= LOOKUP;
          end
        end

        ACK: begin
          cpu_ack <= 1'b1;
          state   <= IDLE;
        end

        FL_SCAN: begin
          if (valid[fl_set][fl_way] && dirty[fl_set][fl_way]) begin
            state <= FL_WB;
          end else begin
            valid[fl_set][fl_way] <= 1'b0;
            dirty[fl_set][fl_way] <= 1'b0;
            if (fl_last) begin
              state <= FL_DONE;
            end else if (fl_set == SET_W'(SETS - 1)) begin
              fl_set <= '0;
              fl_way <= fl_way + AGE_W'(1);
            end else begin
              fl_set <= fl_set + SET_W'(1);
            end
          end
        end

        FL_WB: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {tag_mem[fl_way][fl_set], fl_set};
            mem_wdata <= data_mem[fl_way][fl_set];
          end else if (mem_ack) begin
            mem_req               <= 1'b0;
            mem_we                <= 1'b0;
            valid[fl_set][fl_way] <= 1'b0;
            dirty[fl_set][fl_way] <= 1'b0;
            if (fl_last) begin
              state <= FL_DONE;
            end else begin
              state <= FL_SCAN;
              if (fl_set == SET_W'(SETS - 1)) begin
                fl_set <= '0;
                fl_way <= fl_way + AGE_W'(1);
              end else begin
                fl_set <= fl_set + SET_W'(1);
              end
            end
          end
        end

        FL_DONE: begin
          flush_done <= 1'b1;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_nway_wb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_cache_nway_wb                                               |
// | Purpose : Directed self-checking bench for cache_nway_wb. A 2-way and a  |
// |           4-way instance share the stimulus; 'sel' picks the active one. |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_cache_nway_wb;

  logic         clk = 1'b0;
  logic         R = 1'b1;
  logic         sel = 1'b0;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [1:0]   cpu_size = 2'd0;
  logic [18:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic         flush_req = 1'b0;
  logic [127:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;

  logic [31:0]  c2_rdata, c4_rdata;
  logic         c2_ack, c4_ack, f2_done, f4_done;
  logic         m2_req, m4_req, m2_we, m4_we;
  logic [14:0]  m2_addr, m4_addr;
  logic [127:0] m2_wdata, m4_wdata;
  logic [15:0]  h2, h4, x2, x4;

  always #5 clk = ~clk;

  cache_nway_wb dut2 (
    .clk(clk), .R(R),
    .cpu_req(cpu_req & ~sel), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(c2_rdata), .cpu_ack(c2_ack),
    .flush_req(flush_req & ~sel), .flush_done(f2_done),
    .mem_req(m2_req), .mem_we(m2_we), .mem_addr(m2_addr), .mem_wdata(m2_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack & ~sel),
    .hit_cnt(h2), .miss_cnt(x2)
  );

  cache_nway_wb #(.WAYS(4)) dut4 (
    .clk(clk), .R(R),
    .cpu_req(cpu_req & sel), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(c4_rdata), .cpu_ack(c4_ack),
    .flush_req(flush_req & sel), .flush_done(f4_done),
    .mem_req(m4_req), .mem_we(m4_we), .mem_addr(m4_addr), .mem_wdata(m4_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack & sel),
    .hit_cnt(h4), .miss_cnt(x4)
  );

  wire [31:0]  rdata_m  = sel ? c4_rdata : c2_rdata;
  wire         ack_m    = sel ? c4_ack   : c2_ack;
  wire         fdone_m  = sel ? f4_done  : f2_done;
  wire         mreq_m   = sel ? m4_req   : m2_req;
  wire         mwe_m    = sel ? m4_we    : m2_we;
  wire [14:0]  maddr_m  = sel ? m4_addr  : m2_addr;
  wire [127:0] mwdata_m = sel ? m4_wdata : m2_wdata;
  wire [15:0]  hit_m    = sel ? h4 : h2;
  wire [15:0]  miss_m   = sel ? x4 : x2;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model and transaction log
  logic [127:0] mem_model [logic [14:0]];
  int           wr_cnt = 0, rd_cnt = 0, seq = 0, wr_seq = 0, rd_seq = 0;
  logic [14:0]  last_wr_addr = '0, last_rd_addr = '0;
  logic [127:0] last_wr_data = '0;

  function automatic logic [127:0] def_line(input logic [14:0] a);
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = 8'(k) ^ a[7:0];
    return l;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic we, input logic [1:0] size, input logic [18:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
    lat = 0;
    while (!ack_m && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("cpu_ack_seen", ack_m, 1'b1);
    rdata   = rdata_m;
    cpu_req = 1'b0;
  endtask

  task automatic do_flush();
    int cyc;
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    cyc = 0;
    while (!fdone_m && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("flush_done_seen", fdone_m, 1'b1);
    @(negedge clk);
    check("flush_done_pulse", fdone_m, 1'b0);
  endtask

  // Memory responder: acks each transaction three cycles after it appears.
  initial begin
    forever begin
      @(negedge clk);
      if (mreq_m && !mem_ack) begin
        seq++;
        if (mwe_m) begin
          wr_cnt++;
          wr_seq       = seq;
          last_wr_addr = maddr_m;
          last_wr_data = mwdata_m;
          mem_model[maddr_m] = mwdata_m;
        end else begin
          rd_cnt++;
          rd_seq       = seq;
          last_rd_addr = maddr_m;
          mem_rdata    = mem_model.exists(maddr_m) ? mem_model[maddr_m] : def_line(maddr_m);
        end
        repeat (2) @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  rd;
    logic [127:0] exp_line;
    int           lat, n, wr0, rd0;

    // Line 0x001 holds byte k = k
    for (int k = 0; k < 16; k++) exp_line[8*k +: 8] = 8'(k);
    mem_model[15'h001] = exp_line;

    repeat (3) @(negedge clk);
    R = 1'b0;
    check("rst_cpu_ack", ack_m, 1'b0);
    check("rst_mem_req", mreq_m, 1'b0);
    check("rst_flush_done", fdone_m, 1'b0);
    check("rst_hit_cnt", hit_m, 16'd0);
    check("rst_miss_cnt", miss_m, 16'd0);

    // Cold read miss
    access(1'b0, 2'd2, 19'h00014, 32'h0, rd, lat);
    check("miss_rdata", rd, 32'h04050607);
    check("miss_rd_cnt", rd_cnt, 1);
    check("miss_rd_addr", last_rd_addr, 15'h001);
    check("miss_cnt_1", miss_m, 16'd1);
    check("miss_hit_cnt_0", hit_m, 16'd0);

    // Same read hits, no memory traffic, fixed latency
    access(1'b0, 2'd2, 19'h00014, 32'h0, rd, lat);
    check("hit_rdata", rd, 32'h04050607);
    check("hit_latency", lat, 3);
    check("hit_no_mem", rd_cnt, 1);
    check("hit_cnt_1", hit_m, 16'd1);

    // Byte write hit, then 16-bit read sees merged byte
    access(1'b1, 2'd0, 19'h00015, 32'h000000AA, rd, lat);
    check("wr_hit_latency", lat, 3);
    check("wr_hit_cnt", hit_m, 16'd2);
    access(1'b0, 2'd1, 19'h00014, 32'h0, rd, lat);
    check("rd16_rdata", rd, 32'h000004AA);

    // Misaligned 32-bit and size=3 both align down to offset 4
    access(1'b0, 2'd2, 19'h00017, 32'h0, rd, lat);
    check("rd32_align", rd, 32'h04AA0607);
    access(1'b0, 2'd3, 19'h00016, 32'h0, rd, lat);
    check("rd_size3", rd, 32'h04AA0607);
    check("hit_cnt_5", hit_m, 16'd5);
    check("no_wb_yet", wr_cnt, 0);

    // Second tag in set 1 goes to the free way
    access(1'b0, 2'd2, 19'h00210, 32'h0, rd, lat);
    check("fill2_rdata", rd, 32'h21202322);
    check("fill2_rd_addr", last_rd_addr, 15'h021);
    check("fill2_no_wb", wr_cnt, 0);

    // Third tag evicts LRU dirty line 0x001
    access(1'b0, 2'd0, 19'h00410, 32'h0, rd, lat);
    exp_line[8*5 +: 8] = 8'hAA;
    check("evict_wr_cnt", wr_cnt, 1);
    check("evict_wr_addr", last_wr_addr, 15'h001);
    check("evict_wr_data", last_wr_data, exp_line);
    check("evict_rd_addr", last_rd_addr, 15'h041);
    check("wb_before_fill", (wr_seq < rd_seq), 1'b1);
    check("evict_rdata", rd, 32'h00000041);
    check("miss_cnt_3", miss_m, 16'd3);

    // Dirty one line, then flush: exactly one write-back
    access(1'b1, 2'd1, 19'h00210, 32'h0000BEEF, rd, lat);
    check("hit_cnt_6", hit_m, 16'd6);
    do_flush();
    exp_line = def_line(15'h021);
    exp_line[7:0]  = 8'hBE;
    exp_line[15:8] = 8'hEF;
    check("flush_wr_cnt", wr_cnt, 2);
    check("flush_wr_addr", last_wr_addr, 15'h021);
    check("flush_wr_data", last_wr_data, exp_line);
    rd0 = rd_cnt;
    access(1'b0, 2'd2, 19'h00014, 32'h0, rd, lat);
    check("post_flush_miss", miss_m, 16'd4);
    check("post_flush_fill", rd_cnt, rd0 + 1);
    check("post_flush_rdata", rd, 32'h04AA0607);

    // Reset while FILL waits for memory
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'd2; cpu_addr = 19'h00810;
    n = 0;
    while (!mreq_m && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("fill_pending", mreq_m, 1'b1);
    R = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    check("rst_fill_mem_req", mreq_m, 1'b0);
    check("rst_fill_cpu_ack", ack_m, 1'b0);
    check("rst_fill_miss_cnt", miss_m, 16'd0);
    R = 1'b0;
    repeat (8) @(negedge clk);
    check("late_ack_mem_req", mreq_m, 1'b0);
    check("late_ack_cpu_ack", ack_m, 1'b0);
    rd0 = rd_cnt;
    access(1'b0, 2'd2, 19'h00014, 32'h0, rd, lat);
    check("rst_then_miss", miss_m, 16'd1);
    check("rst_then_fill", rd_cnt, rd0 + 1);
    check("rst_then_rdata", rd, 32'h04AA0607);

    // 4-way LRU: fill tags 0..3 in set 0, touch 0,1,2, then tag 4
    @(negedge clk);
    sel = 1'b1;
    wr0 = wr_cnt;
    for (int t = 0; t < 4; t++) access(1'b0, 2'd2, 19'(t * 32'h200), 32'h0, rd, lat);
    check("w4_miss_4", miss_m, 16'd4);
    for (int t = 0; t < 3; t++) access(1'b0, 2'd2, 19'(t * 32'h200), 32'h0, rd, lat);
    check("w4_hit_3", hit_m, 16'd3);
    access(1'b0, 2'd2, 19'h00800, 32'h0, rd, lat);
    check("w4_tag4_rdata", rd, 32'h80818283);
    check("w4_miss_5", miss_m, 16'd5);
    rd0 = rd_cnt;
    for (int t = 0; t < 3; t++) access(1'b0, 2'd2, 19'(t * 32'h200), 32'h0, rd, lat);
    check("w4_kept_hits", hit_m, 16'd6);
    check("w4_kept_no_fill", rd_cnt, rd0);
    access(1'b0, 2'd2, 19'h00600, 32'h0, rd, lat);
    check("w4_tag3_evicted", miss_m, 16'd6);
    check("w4_tag3_refill", last_rd_addr, 15'h060);
    check("w4_clean_no_wb", wr_cnt, wr0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
